// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared types and constants for the memory access unit.
//               Covers operation codes, FSM states and bus size encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    // Operation codes presented to the memory stage
    typedef enum logic [3:0] {
        NONE = 4'd0,
        LB   = 4'd1,
        LBU  = 4'd2,
        LH   = 4'd3,
        LHU  = 4'd4,
        LW   = 4'd5,
        SB   = 4'd6,
        SH   = 4'd7,
        SW   = 4'd8,
        LWL  = 4'd9,
        LWR  = 4'd10,
        SWL  = 4'd11,
        SWR  = 4'd12
    } mem_op_t;

    // Transaction sequencer states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_DRAIN = 3'd4
    } mas_state_t;

    // Bus size encodings
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

endpackage
`default_nettype wire

// File: rtl/mem_load_format.sv
`default_nettype none
// ============================================================================
// Module      : mem_load_format
// Description : Combinational load-data formatter. Selects the addressed
//               lane, sign/zero extends, and merges with rt for LWL/LWR.
//               LWL/LWR merging exists only when MEM_UNALIGNED_LR_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_load_format
    import mem_pkg::*;
(
    input  logic [3:0]  i_op,
    input  logic [1:0]  i_lane,
    input  logic [31:0] i_mdata,
    input  logic [31:0] i_rt,
    output logic [31:0] o_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_mdata[{i_lane, 3'b000} +: 8];
    assign w_half = i_lane[1] ? i_mdata[31:16] : i_mdata[15:0];

    // Extend or merge the returned word according to the operation
    always_comb begin
        o_result = '0;
        case (i_op)
            LB:  o_result = {{24{w_byte[7]}}, w_byte};
            LBU: o_result = {24'd0, w_byte};
            LH:  o_result = {{16{w_half[15]}}, w_half};
            LHU: o_result = {16'd0, w_half};
            LW:  o_result = i_mdata;
`ifdef MEM_UNALIGNED_LR_EN
            LWL: begin
                case (i_lane)
                    2'd0:    o_result = {i_mdata[7:0],  i_rt[23:0]};
                    2'd1:    o_result = {i_mdata[15:0], i_rt[15:0]};
                    2'd2:    o_result = {i_mdata[23:0], i_rt[7:0]};
                    default: o_result = i_mdata;
                endcase
            end
            LWR: begin
                case (i_lane)
                    2'd0:    o_result = i_mdata;
                    2'd1:    o_result = {i_rt[31:24], i_mdata[31:8]};
                    2'd2:    o_result = {i_rt[31:16], i_mdata[31:16]};
                    default: o_result = {i_rt[31:8],  i_mdata[31:24]};
                endcase
            end
`endif
            default: o_result = '0;
        endcase
    end

`ifndef MEM_UNALIGNED_LR_EN
    // rt only feeds the LWL/LWR merge paths
    logic w_unused;
    assign w_unused = ^i_rt;
`endif

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : MEM-stage load/store unit. Checks alignment, issues one
//               transaction on a req/addr_ok/data_ok bus, formats load data
//               and stalls the pipeline until the transaction completes.
//               Optional macro MEM_UNALIGNED_LR_EN enables LWL/LWR/SWL/SWR.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32
)
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              mem_valid_i,
    input  logic [3:0]        mem_op_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       rt_i,
    input  logic              flush_i,
    input  logic              pipe_advance_i,
    output logic              data_req_o,
    output logic              data_wr_o,
    output logic [1:0]        data_size_o,
    output logic [ADDR_W-1:0] data_addr_o,
    output logic [3:0]        data_wstrb_o,
    output logic [31:0]       data_wdata_o,
    input  logic              data_addr_ok_i,
    input  logic              data_data_ok_i,
    input  logic [31:0]       data_rdata_i,
    output logic [31:0]       rdata_o,
    output logic              done_o,
    output logic              mem_stall_o,
    output logic              adel_o,
    output logic              ades_o,
    output logic [ADDR_W-1:0] bad_vaddr_o
);

    mas_state_t        r_state, w_next_state;
    logic [3:0]        r_op;
    logic [1:0]        r_lane;
    logic [31:0]       r_rt;
    logic              r_wr;
    logic [1:0]        r_size;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_wstrb;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;

    logic              w_supported, w_accept, w_capture, w_stall;
    logic              w_wr;
    logic [1:0]        w_size;
    logic [ADDR_W-1:0] w_baddr;
    logic [3:0]        w_wstrb;
    logic [31:0]       w_wdata;
    logic [31:0]       w_fmt;

    // Alignment faults are reported combinationally for the current instruction
    assign adel_o = mem_valid_i &
                    ((((mem_op_i == LH) || (mem_op_i == LHU)) && addr_i[0]) ||
                     ((mem_op_i == LW) && (addr_i[1:0] != 2'b00)));
    assign ades_o = mem_valid_i &
                    (((mem_op_i == SH) && addr_i[0]) ||
                     ((mem_op_i == SW) && (addr_i[1:0] != 2'b00)));
    assign bad_vaddr_o = addr_i;

`ifdef MEM_UNALIGNED_LR_EN
    assign w_supported = (mem_op_i != NONE) && (mem_op_i <= SWR);
`else
    // Partial-word ops decode as no operation when unsupported
    assign w_supported = (mem_op_i != NONE) && (mem_op_i <= SW);
`endif

    assign w_accept = (r_state == ST_IDLE) & mem_valid_i & w_supported &
                      ~adel_o & ~ades_o & ~flush_i;

`ifdef MEM_UNALIGNED_LR_EN
    logic [ADDR_W-1:0] w_aligned;
    assign w_aligned = {addr_i[ADDR_W-1:2], 2'b00};
`endif

    // Build the bus request fields from the incoming instruction
    always_comb begin
        w_wr    = 1'b0;
        w_size  = SZ_WORD;
        w_baddr = addr_i;
        w_wstrb = 4'b0000;
        w_wdata = 32'd0;
        case (mem_op_i)
            LB, LBU: w_size = SZ_BYTE;
            LH, LHU: w_size = SZ_HALF;
            SB: begin
                w_wr    = 1'b1;
                w_size  = SZ_BYTE;
                w_wstrb = 4'b0001 << addr_i[1:0];
                w_wdata = {4{rt_i[7:0]}};
            end
            SH: begin
                w_wr    = 1'b1;
                w_size  = SZ_HALF;
                w_wstrb = addr_i[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{rt_i[15:0]}};
            end
            SW: begin
                w_wr    = 1'b1;
                w_wstrb = 4'b1111;
                w_wdata = rt_i;
            end
`ifdef MEM_UNALIGNED_LR_EN
            LWL, LWR: w_baddr = w_aligned;
            SWL: begin
                w_wr    = 1'b1;
                w_baddr = w_aligned;
                w_wstrb = 4'b1111 >> (2'd3 - addr_i[1:0]);
                w_wdata = rt_i >> (5'd24 - {addr_i[1:0], 3'b000});
            end
            SWR: begin
                w_wr    = 1'b1;
                w_baddr = w_aligned;
                w_wstrb = 4'b1111 << addr_i[1:0];
                w_wdata = rt_i << {addr_i[1:0], 3'b000};
            end
`endif
            default: w_size = SZ_WORD;
        endcase
    end

    mem_load_format u_fmt (
        .i_op     (r_op),
        .i_lane   (r_lane),
        .i_mdata  (data_rdata_i),
        .i_rt     (r_rt),
        .o_result (w_fmt)
    );

    // Next-state, stall and result-capture decode
    always_comb begin
        w_next_state = r_state;
        w_stall      = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = ST_REQ;
                    w_stall      = 1'b1;
                end
            end
            ST_REQ: begin
                w_stall = 1'b1;
                if (flush_i) begin
                    // Withdraw if not yet accepted; otherwise drain the response
                    if (!data_addr_ok_i || data_data_ok_i) w_next_state = ST_IDLE;
                    else                                   w_next_state = ST_DRAIN;
                end else if (data_addr_ok_i) begin
                    if (data_data_ok_i) begin
                        w_next_state = ST_DONE;
                        w_capture    = 1'b1;
                    end else begin
                        w_next_state = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                w_stall = 1'b1;
                if (data_data_ok_i) begin
                    if (flush_i) begin
                        w_next_state = ST_IDLE;
                    end else begin
                        w_next_state = ST_DONE;
                        w_capture    = 1'b1;
                    end
                end else if (flush_i) begin
                    w_next_state = ST_DRAIN;
                end
            end
            ST_DONE: begin
                if (pipe_advance_i || flush_i) w_next_state = ST_IDLE;
            end
            ST_DRAIN: begin
                w_stall = mem_valid_i;
                if (data_data_ok_i) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // State register, request latch and result capture
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_op    <= 4'd0;
            r_lane  <= 2'd0;
            r_rt    <= 32'd0;
            r_wr    <= 1'b0;
            r_size  <= 2'd0;
            r_addr  <= '0;
            r_wstrb <= 4'd0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_op    <= mem_op_i;
                r_lane  <= addr_i[1:0];
                r_rt    <= rt_i;
                r_wr    <= w_wr;
                r_size  <= w_size;
                r_addr  <= w_baddr;
                r_wstrb <= w_wstrb;
                r_wdata <= w_wdata;
            end
            if (w_capture) r_rdata <= w_fmt;
        end
    end

    assign data_req_o   = (r_state == ST_REQ);
    assign data_wr_o    = r_wr;
    assign data_size_o  = r_size;
    assign data_addr_o  = r_addr;
    assign data_wstrb_o = r_wstrb;
    assign data_wdata_o = r_wdata;
    assign done_o       = (r_state == ST_DONE);
    assign rdata_o      = done_o ? r_rdata : 32'd0;
    assign mem_stall_o  = w_stall;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Directed bench for mem_access_unit: vector table of single
//               transactions plus hand-written multi-cycle sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;
    import mem_pkg::*;

    localparam int ADDR_W = 32;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              mem_valid_i;
    logic [3:0]        mem_op_i;
    logic [ADDR_W-1:0] addr_i;
    logic [31:0]       rt_i;
    logic              flush_i;
    logic              pipe_advance_i;
    logic              data_req_o;
    logic              data_wr_o;
    logic [1:0]        data_size_o;
    logic [ADDR_W-1:0] data_addr_o;
    logic [3:0]        data_wstrb_o;
    logic [31:0]       data_wdata_o;
    logic              data_addr_ok_i;
    logic              data_data_ok_i;
    logic [31:0]       data_rdata_i;
    logic [31:0]       rdata_o;
    logic              done_o;
    logic              mem_stall_o;
    logic              adel_o;
    logic              ades_o;
    logic [ADDR_W-1:0] bad_vaddr_o;

    int n_checks = 0;
    int n_fail   = 0;

    mem_access_unit #(.ADDR_W(ADDR_W)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .mem_valid_i    (mem_valid_i),
        .mem_op_i       (mem_op_i),
        .addr_i         (addr_i),
        .rt_i           (rt_i),
        .flush_i        (flush_i),
        .pipe_advance_i (pipe_advance_i),
        .data_req_o     (data_req_o),
        .data_wr_o      (data_wr_o),
        .data_size_o    (data_size_o),
        .data_addr_o    (data_addr_o),
        .data_wstrb_o   (data_wstrb_o),
        .data_wdata_o   (data_wdata_o),
        .data_addr_ok_i (data_addr_ok_i),
        .data_data_ok_i (data_data_ok_i),
        .data_rdata_i   (data_rdata_i),
        .rdata_o        (rdata_o),
        .done_o         (done_o),
        .mem_stall_o    (mem_stall_o),
        .adel_o         (adel_o),
        .ades_o         (ades_o),
        .bad_vaddr_o    (bad_vaddr_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] rt;
        logic [31:0] mdata;
        logic        issue;
        logic        adel;
        logic        ades;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] baddr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [3:0] op, input logic [31:0] addr,
                                input logic [31:0] rt, input logic [31:0] mdata,
                                input logic issue, input logic adel, input logic ades,
                                input logic wr, input logic [1:0] size,
                                input logic [31:0] baddr, input logic [3:0] wstrb,
                                input logic [31:0] wdata, input logic [31:0] rdata);
        vec_t v;
        v.op = op; v.addr = addr; v.rt = rt; v.mdata = mdata;
        v.issue = issue; v.adel = adel; v.ades = ades; v.wr = wr;
        v.size = size; v.baddr = baddr; v.wstrb = wstrb; v.wdata = wdata;
        v.rdata = rdata;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic drive_instr(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] rt);
        mem_valid_i = 1'b1;
        mem_op_i    = op;
        addr_i      = addr;
        rt_i        = rt;
    endtask

    task automatic idle_inputs();
        mem_valid_i    = 1'b0;
        mem_op_i       = 4'd0;
        addr_i         = '0;
        rt_i           = 32'd0;
        flush_i        = 1'b0;
        pipe_advance_i = 1'b0;
        data_addr_ok_i = 1'b0;
        data_data_ok_i = 1'b0;
        data_rdata_i   = 32'd0;
    endtask

    // One transaction from a table row, bus answering addr_ok & data_ok together
    task automatic run_vec(input vec_t v, input int idx);
        drive_instr(v.op, v.addr, v.rt);
        #1;
        check($sformatf("v%0d.adel", idx), {31'd0, adel_o}, {31'd0, v.adel});
        check($sformatf("v%0d.ades", idx), {31'd0, ades_o}, {31'd0, v.ades});
        check($sformatf("v%0d.bad_vaddr", idx), bad_vaddr_o, v.addr);
        check($sformatf("v%0d.stall_accept", idx), {31'd0, mem_stall_o}, {31'd0, v.issue});
        tick();
        if (!v.issue) begin
            check($sformatf("v%0d.no_req", idx), {31'd0, data_req_o}, 32'd0);
            idle_inputs();
        end else begin
            check($sformatf("v%0d.req", idx), {31'd0, data_req_o}, 32'd1);
            check($sformatf("v%0d.wr", idx), {31'd0, data_wr_o}, {31'd0, v.wr});
            check($sformatf("v%0d.size", idx), {30'd0, data_size_o}, {30'd0, v.size});
            check($sformatf("v%0d.addr", idx), data_addr_o, v.baddr);
            check($sformatf("v%0d.wstrb", idx), {28'd0, data_wstrb_o}, {28'd0, v.wstrb});
            if (v.wr) check($sformatf("v%0d.wdata", idx), data_wdata_o, v.wdata);
            data_addr_ok_i = 1'b1;
            data_data_ok_i = 1'b1;
            data_rdata_i   = v.mdata;
            tick();
            data_addr_ok_i = 1'b0;
            data_data_ok_i = 1'b0;
            check($sformatf("v%0d.done", idx), {31'd0, done_o}, 32'd1);
            check($sformatf("v%0d.stall_done", idx), {31'd0, mem_stall_o}, 32'd0);
            if (!v.wr) check($sformatf("v%0d.rdata", idx), rdata_o, v.rdata);
            pipe_advance_i = 1'b1;
            mem_valid_i    = 1'b0;
            tick();
            pipe_advance_i = 1'b0;
            check($sformatf("v%0d.done_clr", idx), {31'd0, done_o}, 32'd0);
        end
    endtask

    initial begin
        int stall_cnt;

        //   op   addr          rt            mdata         iss adl ads wr size     baddr         wstrb    wdata         rdata
        add(LB,  32'h0000_1000, 32'h0,        32'h0000_0085, 1, 0, 0, 0, SZ_BYTE, 32'h0000_1000, 4'b0000, 32'h0,        32'hFFFF_FF85);
        add(LBU, 32'h0000_1002, 32'h0,        32'h00AB_0000, 1, 0, 0, 0, SZ_BYTE, 32'h0000_1002, 4'b0000, 32'h0,        32'h0000_00AB);
        add(LH,  32'h0000_1002, 32'h0,        32'h8001_1234, 1, 0, 0, 0, SZ_HALF, 32'h0000_1002, 4'b0000, 32'h0,        32'hFFFF_8001);
        add(LHU, 32'h0000_1000, 32'h0,        32'h1234_FEDC, 1, 0, 0, 0, SZ_HALF, 32'h0000_1000, 4'b0000, 32'h0,        32'h0000_FEDC);
        add(LW,  32'h0000_1004, 32'h0,        32'hCAFE_F00D, 1, 0, 0, 0, SZ_WORD, 32'h0000_1004, 4'b0000, 32'h0,        32'hCAFE_F00D);
        add(SB,  32'h0000_2001, 32'h0000_00A5, 32'h0,        1, 0, 0, 1, SZ_BYTE, 32'h0000_2001, 4'b0010, 32'hA5A5_A5A5, 32'h0);
        add(SH,  32'h0000_2002, 32'h0000_ABCD, 32'h0,        1, 0, 0, 1, SZ_HALF, 32'h0000_2002, 4'b1100, 32'hABCD_ABCD, 32'h0);
        add(SH,  32'h0000_2000, 32'h1234_5678, 32'h0,        1, 0, 0, 1, SZ_HALF, 32'h0000_2000, 4'b0011, 32'h5678_5678, 32'h0);
        add(SW,  32'h0000_2008, 32'h1234_5678, 32'h0,        1, 0, 0, 1, SZ_WORD, 32'h0000_2008, 4'b1111, 32'h1234_5678, 32'h0);
        add(LW,  32'h0000_3001, 32'h0,        32'h0,         0, 1, 0, 0, SZ_BYTE, 32'h0,         4'b0000, 32'h0,        32'h0);
        add(LH,  32'h0000_3001, 32'h0,        32'h0,         0, 1, 0, 0, SZ_BYTE, 32'h0,         4'b0000, 32'h0,        32'h0);
        add(LHU, 32'h0000_3003, 32'h0,        32'h0,         0, 1, 0, 0, SZ_BYTE, 32'h0,         4'b0000, 32'h0,        32'h0);
        add(SH,  32'h0000_3003, 32'h0,        32'h0,         0, 0, 1, 0, SZ_BYTE, 32'h0,         4'b0000, 32'h0,        32'h0);
        add(SW,  32'h0000_3002, 32'h0,        32'h0,         0, 0, 1, 0, SZ_BYTE, 32'h0,         4'b0000, 32'h0,        32'h0);
        add(NONE,32'h0000_3000, 32'h0,        32'h0,         0, 0, 0, 0, SZ_BYTE, 32'h0,         4'b0000, 32'h0,        32'h0);
`ifdef MEM_UNALIGNED_LR_EN
        add(LWL, 32'h0000_4001, 32'h1122_3344, 32'hAABB_CCDD, 1, 0, 0, 0, SZ_WORD, 32'h0000_4000, 4'b0000, 32'h0,        32'hCCDD_3344);
        add(LWR, 32'h0000_4002, 32'h1122_3344, 32'hAABB_CCDD, 1, 0, 0, 0, SZ_WORD, 32'h0000_4000, 4'b0000, 32'h0,        32'h1122_AABB);
        add(SWR, 32'h0000_4002, 32'h1122_3344, 32'h0,        1, 0, 0, 1, SZ_WORD, 32'h0000_4000, 4'b1100, 32'h3344_0000, 32'h0);
        add(SWL, 32'h0000_4001, 32'h1122_3344, 32'h0,        1, 0, 0, 1, SZ_WORD, 32'h0000_4000, 4'b0011, 32'h0000_1122, 32'h0);
`else
        add(LWL, 32'h0000_4001, 32'h1122_3344, 32'hAABB_CCDD, 0, 0, 0, 0, SZ_BYTE, 32'h0,        4'b0000, 32'h0,        32'h0);
        add(SWR, 32'h0000_4002, 32'h1122_3344, 32'h0,        0, 0, 0, 0, SZ_BYTE, 32'h0,         4'b0000, 32'h0,        32'h0);
`endif

        idle_inputs();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        #1;
        check("reset.req",   {31'd0, data_req_o},   32'd0);
        check("reset.done",  {31'd0, done_o},       32'd0);
        check("reset.stall", {31'd0, mem_stall_o},  32'd0);
        check("reset.rdata", rdata_o,               32'd0);
        check("reset.wstrb", {28'd0, data_wstrb_o}, 32'd0);
        check("reset.addr",  data_addr_o,           32'd0);
        tick();

        foreach (vecs[i]) run_vec(vecs[i], i);

        // LB lane 3, addr_ok then data_ok two cycles later; DONE held without advance
        stall_cnt = 0;
        drive_instr(LB, 32'h0000_1003, 32'h0);
        #1; stall_cnt += int'(mem_stall_o);
        tick();
        data_addr_ok_i = 1'b1;
        #1; stall_cnt += int'(mem_stall_o);
        check("lb.req", {31'd0, data_req_o}, 32'd1);
        tick();
        data_addr_ok_i = 1'b0;
        #1; stall_cnt += int'(mem_stall_o);
        check("lb.req_drop", {31'd0, data_req_o}, 32'd0);
        tick();
        data_data_ok_i = 1'b1;
        data_rdata_i   = 32'h80FF_FF11;
        #1; stall_cnt += int'(mem_stall_o);
        check("lb.done_early", {31'd0, done_o}, 32'd0);
        tick();
        data_data_ok_i = 1'b0;
        data_rdata_i   = 32'h0;
        check("lb.stall_cycles", stall_cnt, 32'd4);
        check("lb.done", {31'd0, done_o}, 32'd1);
        check("lb.rdata", rdata_o, 32'hFFFF_FF80);
        check("lb.stall_done", {31'd0, mem_stall_o}, 32'd0);
        tick();
        check("lb.done_hold", {31'd0, done_o}, 32'd1);
        check("lb.rdata_hold", rdata_o, 32'hFFFF_FF80);
        pipe_advance_i = 1'b1;
        mem_valid_i    = 1'b0;
        tick();
        pipe_advance_i = 1'b0;
        check("lb.idle", {31'd0, done_o}, 32'd0);

        // Flush while waiting; response arrives three cycles later and is dropped
        drive_instr(LW, 32'h0000_5000, 32'h0);
        tick();
        data_addr_ok_i = 1'b1;
        tick();
        data_addr_ok_i = 1'b0;
        flush_i        = 1'b1;
        mem_valid_i    = 1'b0;
        tick();
        flush_i = 1'b0;
        drive_instr(LW, 32'h0000_5004, 32'h0);
        #1;
        check("drain.stall1", {31'd0, mem_stall_o}, 32'd1);
        check("drain.req1",   {31'd0, data_req_o},  32'd0);
        check("drain.done1",  {31'd0, done_o},      32'd0);
        tick();
        check("drain.stall2", {31'd0, mem_stall_o}, 32'd1);
        tick();
        data_data_ok_i = 1'b1;
        data_rdata_i   = 32'hDEAD_BEEF;
        #1;
        check("drain.done3", {31'd0, done_o},     32'd0);
        check("drain.req3",  {31'd0, data_req_o}, 32'd0);
        tick();
        data_data_ok_i = 1'b0;
        data_rdata_i   = 32'h0;
        check("drain.idle_done", {31'd0, done_o},      32'd0);
        check("drain.accept",    {31'd0, mem_stall_o}, 32'd1);
        tick();
        check("drain.next_req",  {31'd0, data_req_o}, 32'd1);
        check("drain.next_addr", data_addr_o, 32'h0000_5004);
        data_addr_ok_i = 1'b1;
        data_data_ok_i = 1'b1;
        data_rdata_i   = 32'h0102_0304;
        tick();
        data_addr_ok_i = 1'b0;
        data_data_ok_i = 1'b0;
        check("drain.next_rdata", rdata_o, 32'h0102_0304);
        pipe_advance_i = 1'b1;
        mem_valid_i    = 1'b0;
        tick();
        pipe_advance_i = 1'b0;

        // Flush in REQ without addr_ok withdraws the request
        drive_instr(SB, 32'h0000_6000, 32'h55);
        tick();
        flush_i     = 1'b1;
        mem_valid_i = 1'b0;
        #1;
        check("withdraw.req_before", {31'd0, data_req_o}, 32'd1);
        tick();
        flush_i = 1'b0;
        check("withdraw.req_after", {31'd0, data_req_o},  32'd0);
        check("withdraw.stall",     {31'd0, mem_stall_o}, 32'd0);

        // Flush in REQ together with addr_ok goes to DRAIN; stall follows valid there
        drive_instr(LH, 32'h0000_7000, 32'h0);
        tick();
        data_addr_ok_i = 1'b1;
        flush_i        = 1'b1;
        mem_valid_i    = 1'b0;
        tick();
        data_addr_ok_i = 1'b0;
        flush_i        = 1'b0;
        check("rdrain.stall_novalid", {31'd0, mem_stall_o}, 32'd0);
        drive_instr(SW, 32'h0000_7004, 32'h0);
        #1;
        check("rdrain.no_accept", {31'd0, mem_stall_o}, 32'd1);
        tick();
        check("rdrain.no_req", {31'd0, data_req_o}, 32'd0);
        data_data_ok_i = 1'b1;
        tick();
        data_data_ok_i = 1'b0;
        check("rdrain.done", {31'd0, done_o}, 32'd0);
        tick();
        check("rdrain.accept_req", {31'd0, data_req_o}, 32'd1);
        flush_i     = 1'b1;
        mem_valid_i = 1'b0;
        tick();
        flush_i = 1'b0;

        // Flush in IDLE blocks the accept
        drive_instr(SW, 32'h0000_6004, 32'h1);
        flush_i = 1'b1;
        #1;
        check("flush_idle.stall", {31'd0, mem_stall_o}, 32'd0);
        tick();
        check("flush_idle.req", {31'd0, data_req_o}, 32'd0);
        idle_inputs();

        // Reset while a request is outstanding
        drive_instr(SW, 32'h0000_8000, 32'h1234_5678);
        tick();
        mem_valid_i = 1'b0;
        #1;
        check("rst_req.req_before", {31'd0, data_req_o}, 32'd1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("rst_req.req",   {31'd0, data_req_o},   32'd0);
        check("rst_req.done",  {31'd0, done_o},       32'd0);
        check("rst_req.wstrb", {28'd0, data_wstrb_o}, 32'd0);
        tick();
        check("rst_req.idle_req", {31'd0, data_req_o}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage load/store unit directly downstream of the execute ALU.
- Takes the ALU result as the effective address and the rt value as store data.
- Checks alignment, then issues one transaction on an SRAM-like data bus (req/addr_ok/data_ok).
- Formats load data (extend/merge) for writeback and stalls the pipeline until the transaction completes.

Parameters:
- ADDR_W, 32, width of effective address and bus address.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  synchronous, active-high reset
- mem_valid_i  input  1  instruction in MEM stage is valid
- mem_op_i  input  4  mem_op_t operation code
- addr_i  input  ADDR_W  effective address (ALU wdata_o)
- rt_i  input  32  rt value: store data, and merge source for LWL/LWR
- flush_i  input  1  MEM-stage flush (exception/eret)
- pipe_advance_i  input  1  pipeline moves MEM to WB this cycle
- data_req_o  output  1  bus request
- data_wr_o  output  1  1 = store
- data_size_o  output  2  0 = byte, 1 = half, 2 = word
- data_addr_o  output  ADDR_W  bus address
- data_wstrb_o  output  4  byte strobes
- data_wdata_o  output  32  store data
- data_addr_ok_i  input  1  request accepted
- data_data_ok_i  input  1  response/write complete
- data_rdata_i  input  32  load data
- rdata_o  output  32  formatted load result
- done_o  output  1  result valid (state DONE)
- mem_stall_o  output  1  stall request to hazard unit
- adel_o  output  1  load address error
- ades_o  output  1  store address error
- bad_vaddr_o  output  ADDR_W  faulting address (equals addr_i)

Behaviour:
- Reset: state IDLE; all registered outputs 0; data_req_o = 0.
- FSM states: IDLE, REQ, WAIT, DONE, DRAIN.
- Error check (combinational, while mem_valid_i):
  - adel_o: LH/LHU with addr[0]=1, or LW with addr[1:0]!=0.
  - ades_o: SH with addr[0]=1, or SW with addr[1:0]!=0.
  - On error: no request issued, mem_stall_o = 0.
- Accept condition (IDLE): mem_valid_i & op!=NONE & no error & !flush_i.
  - On accept: latch op, addr[1:0], rt_i, bus fields; go to REQ.
  - mem_stall_o = 1 in the accepting cycle.
- REQ: data_req_o = 1, bus fields held stable.
  - addr_ok & data_ok same cycle -> DONE.
  - addr_ok only -> WAIT.
  - flush_i & !addr_ok -> IDLE (request withdrawn).
  - flush_i & addr_ok -> DRAIN, or IDLE if data_ok is also high.
- WAIT: on data_ok, capture formatted rdata -> DONE; flush_i -> DRAIN.
  - flush_i together with data_ok -> IDLE, result discarded.
- DONE: done_o = 1, rdata_o held, stall low; pipe_advance_i or flush_i -> IDLE.
- DRAIN: wait for data_ok, discard response -> IDLE. No new accept; mem_stall_o = mem_valid_i.
- mem_stall_o = 1 in REQ and WAIT.
- Bus formatting:
  - SB: wdata {4{rt[7:0]}}, strobe 1 << addr[1:0].
  - SH: wdata {2{rt[15:0]}}, strobe 0011 or 1100.
  - SW: strobe 1111.
  - data_addr_o = addr_i for byte/half/word; size per op.
- Load extension (little-endian, byte 0 = bits 7:0):
  - LB/LH sign-extend the lane selected by addr.
  - LBU/LHU zero-extend.
  - LW passes the word through.

Optional Feature:
- MEM_UNALIGNED_LR_EN:
  - Defined: LWL/LWR/SWL/SWR supported.
    - Bus address {addr[31:2],2'b00}, size word, never raise address errors.
    - LWL for addr[1:0]=0/1/2/3: {m[7:0],rt[23:0]} / {m[15:0],rt[15:0]} / {m[23:0],rt[7:0]} / m.
    - LWR for 0..3: m / {rt[31:24],m[31:8]} / {rt[31:16],m[31:16]} / {rt[31:8],m[31:24]}.
    - SWL strobes 0001/0011/0111/1111, data rt >> (24 - 8*a).
    - SWR strobes 1111/1110/1100/1000, data rt << (8*a).
  - Undefined: ops 9..12 treated as NONE (no request, no stall, rdata_o = 0).

Decomposition:
- Package mem_pkg:
  - mem_op_t: NONE=0, LB=1, LBU=2, LH=3, LHU=4, LW=5, SB=6, SH=7, SW=8, LWL=9, LWR=10, SWL=11, SWR=12.
  - mas_state_t.
  - Size constants SZ_BYTE/SZ_HALF/SZ_WORD.
- One sub-module, mem_load_format: combinational extension and merge, shared with the test model.

Test Plan:
- LB addr 0x1003, rdata 0x80FF_FF11, addr_ok then data_ok 2 cycles later -> rdata_o = 0xFFFF_FF80; stall high 4 cycles; done_o 1 cycle later.
- SH addr 0x2002, rt 0x0000_ABCD, addr_ok & data_ok same cycle -> wstrb 1100, wdata 0xABCD_ABCD, size 1; DONE next cycle.
- LW addr 0x3001 -> adel_o = 1, bad_vaddr_o = 0x3001, data_req_o never asserted, stall 0.
- Flush in WAIT, data_ok 3 cycles later with 0xDEAD_BEEF -> DRAIN, then IDLE; done_o stays 0; next LW accepted only after data_ok.
- Reset asserted in REQ -> next cycle IDLE, data_req_o = 0, done_o = 0.
- With MEM_UNALIGNED_LR_EN: LWL addr 0x4001, rt 0x1122_3344, mem 0xAABB_CCDD -> rdata_o = 0xCCDD_3344; SWR addr 0x4002 -> strobe 1100, wdata 0x3344_0000.
